alu_issue: RTL and testbench
============================

Name: alu_issue

Overview:
- Decode-and-issue register directly upstream of the execute ALU in the RISC-V CPU.
- Accepts one fetched instruction plus its PC and register-file read data per handshake.
- Decodes the instruction into the 12-bit one-hot ALU opcode and selects both operands.
- Registers the result into a valid/ready pipeline slot that the ALU consumes, with flush support for branch/jump redirects.

Parameters:
- DATA_WIDTH, 32, operand/PC width
- OP_WIDTH, 12, one-hot ALU opcode width
- ILLEGAL_AS_NOP, 1, 1 = illegal instructions issue with alu_op 0 and rf_wen 0; 0 = alu_op forced to add

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- in_valid  in  1  upstream offers an instruction
- in_ready  out  1  slot can accept this cycle
- inst  in  32  instruction word
- pc  in  DATA_WIDTH  instruction address
- rs1_data  in  DATA_WIDTH  register file read port 1
- rs2_data  in  DATA_WIDTH  register file read port 2
- flush  in  1  discard held and incoming instruction
- out_valid  out  1  issued entry valid
- out_ready  in  1  ALU/execute stage consumes entry
- alu_a  out  DATA_WIDTH  ALU operand A
- alu_b  out  DATA_WIDTH  ALU operand B
- alu_op  out  OP_WIDTH  one-hot opcode: b0 add, b1 sub, b2 and, b3 or, b4 auipc, b5 xor, b6 slt, b7 sltu, b8 sll, b9 srl, b10 sra, b11 lui
- rd  out  5  destination register
- rf_wen  out  1  write-back enable
- is_branch  out  1  conditional branch entry
- br_inv  out  1  branch taken when ALU Zero/Result is inverted (bne, bge, bgeu)
- illegal  out  1  unsupported encoding
- out_pc  out  DATA_WIDTH  PC of issued entry

Behaviour:
- Reset (rst low, async): out_valid 0; alu_a, alu_b, alu_op, rd, out_pc 0; rf_wen, is_branch, br_inv, illegal 0.
- Handshake: in_ready = !out_valid | out_ready (combinational). Accept when in_valid & in_ready; entry appears on outputs the next cycle (latency 1).
- Outputs hold stable while out_valid & !out_ready.
- flush: next cycle out_valid = 0; an acceptance in the same cycle is dropped; flush dominates accept. Payload registers may keep stale data.
- Decode by opcode (inst[6:0]):
  - OP 0110011: A = rs1, B = rs2; funct3/funct7 map to add/sub/sll/slt/sltu/xor/srl/sra/or/and; rf_wen = 1.
  - OP-IMM 0010011: A = rs1, B = sign-extended I-imm. Shifts use B = {27'b0, shamt}, with funct7 0000000 (or 0100000 for srai), else illegal.
  - LUI 0110111: A = 0, B = {12'b0, inst[31:12]}, op = lui. The ALU shifts B left by 12 itself.
  - AUIPC 0010111: A = pc, B = {12'b0, inst[31:12]}, op = auipc.
  - LOAD 0000011 / STORE 0100011: op = add, A = rs1, B = sign-extended I/S-imm; rf_wen = load.
  - BRANCH 1100011: A = rs1, B = rs2; beq/bne use sub, blt/bge use slt, bltu/bgeu use sltu; is_branch = 1; br_inv per funct3; rf_wen = 0; funct3 010/011 illegal.
  - Any other encoding: illegal = 1, rf_wen = 0, alu_op per ILLEGAL_AS_NOP.
- rd = inst[11:7]; rf_wen is forced 0 when rd == 0.
- alu_op is exactly one-hot or all-zero; never multi-hot.

Optional Feature:
- Macro: ALU_ISSUE_SKID_EN.
- Defined: adds a one-entry skid register so in_ready is a pure flop output (in_ready = !skid_valid). An accept while the main slot is stalled lands in the skid entry, which moves to the main slot when out_ready rises. flush clears both entries. Ordering is preserved.
- Undefined: single slot, combinational in_ready as above.

Decomposition:
- Shared package/header alu_defs holds:
  - ALU opcode bit indices (ALU_ADD ... ALU_LUI) and OP_WIDTH/DATA_WIDTH constants.
  - RV32I opcode constants and funct3 constants.
  - The same constants are used by the ALU.
- One sub-module, imm_gen (combinational I/S/U immediate extraction and sign-extension), keeps the decode body readable.
- The skid logic stays inline.

Test Plan:
- Reset: hold rst low mid-stream with out_valid = 1 -> out_valid 0, alu_op 0 immediately, in_ready 1.
- add x3,x1,x2, rs1 = 5, rs2 = 7 -> next cycle alu_op = 0x001, A = 5, B = 7, rd = 3, rf_wen 1.
- lui x5,0xABCDE -> alu_op = 0x800, B = 0x000ABCDE. auipc at pc = 0x1000 with imm 0x1 -> alu_op = 0x010, A = 0x1000, B = 0x1.
- srai x1,x2,4 (inst 0x40415093) -> alu_op = 0x400, B = 4. Same with funct7 0x10 -> illegal 1, rf_wen 0.
- Stall/flush: out_ready 0 for 3 cycles -> outputs stable, in_ready 0 (1 when skid entry empty under ALU_ISSUE_SKID_EN). Flush concurrent with in_valid -> out_valid 0 next cycle, instruction lost.
- bgeu, rs1 = 1, rs2 = 0xFFFFFFFF -> alu_op = 0x080, is_branch 1, br_inv 1, rf_wen 0.

Source files
------------

// File: rtl/alu_defs.sv
// Shared ALU/decode constants: one-hot opcode bit indices, widths and RV32I encodings.
// The execute ALU imports this package too, so bit positions stay in one place.
package alu_defs;

    localparam int DATA_WIDTH = 32;
    localparam int OP_WIDTH   = 12;

    // Bit positions inside the one-hot ALU opcode
    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_AND   = 4'd2;
    localparam logic [3:0] ALU_OR    = 4'd3;
    localparam logic [3:0] ALU_AUIPC = 4'd4;
    localparam logic [3:0] ALU_XOR   = 4'd5;
    localparam logic [3:0] ALU_SLT   = 4'd6;
    localparam logic [3:0] ALU_SLTU  = 4'd7;
    localparam logic [3:0] ALU_SLL   = 4'd8;
    localparam logic [3:0] ALU_SRL   = 4'd9;
    localparam logic [3:0] ALU_SRA   = 4'd10;
    localparam logic [3:0] ALU_LUI   = 4'd11;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

endpackage

// File: rtl/alu_issue_imm_gen.sv
// imm_gen: combinational RV32I immediate extraction (I, S, U and shift amount).
// U-immediate is left unshifted; the ALU applies the 12-bit shift for lui/auipc.
module imm_gen #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [31:7]           inst,
    output logic [DATA_WIDTH-1:0] i_imm,
    output logic [DATA_WIDTH-1:0] s_imm,
    output logic [DATA_WIDTH-1:0] u_imm,
    output logic [DATA_WIDTH-1:0] shamt
);

    assign i_imm = {{(DATA_WIDTH-12){inst[31]}}, inst[31:20]};
    assign s_imm = {{(DATA_WIDTH-12){inst[31]}}, inst[31:25], inst[11:7]};
    assign u_imm = {{(DATA_WIDTH-20){1'b0}}, inst[31:12]};
    assign shamt = {{(DATA_WIDTH-5){1'b0}}, inst[24:20]};

endmodule

// File: rtl/alu_issue.sv
// alu_issue: decode-and-issue slot in front of the execute ALU (valid/ready, flush).
// Define ALU_ISSUE_SKID_EN for a one-entry skid buffer giving a registered in_ready.
module alu_issue #(
    parameter int DATA_WIDTH     = 32,
    parameter int OP_WIDTH       = 12,
    parameter int ILLEGAL_AS_NOP = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           inst,
    input  logic [DATA_WIDTH-1:0] pc,
    input  logic [DATA_WIDTH-1:0] rs1_data,
    input  logic [DATA_WIDTH-1:0] rs2_data,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    output logic [OP_WIDTH-1:0]   alu_op,
    output logic [4:0]            rd,
    output logic                  rf_wen,
    output logic                  is_branch,
    output logic                  br_inv,
    output logic                  illegal,
    output logic [DATA_WIDTH-1:0] out_pc
);
    import alu_defs::*;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] a;
        logic [DATA_WIDTH-1:0] b;
        logic [DATA_WIDTH-1:0] pc;
        logic [OP_WIDTH-1:0]   op;
        logic [4:0]            rd;
        logic                  wen;
        logic                  br;
        logic                  inv;
        logic                  ill;
    } entry_t;

    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic [6:0]            funct7;
    logic [DATA_WIDTH-1:0] i_imm;
    logic [DATA_WIDTH-1:0] s_imm;
    logic [DATA_WIDTH-1:0] u_imm;
    logic [DATA_WIDTH-1:0] shamt;
    logic [3:0]            op_idx;
    logic                  op_en;
    logic                  wen;
    entry_t                dec;
    entry_t                main_q;

    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign funct7 = inst[31:25];

    imm_gen #(.DATA_WIDTH(DATA_WIDTH)) u_imm_gen (
        .inst  (inst[31:7]),
        .i_imm (i_imm),
        .s_imm (s_imm),
        .u_imm (u_imm),
        .shamt (shamt)
    );

    always_comb begin
        dec     = '0;
        dec.a   = rs1_data;
        dec.b   = rs2_data;
        dec.pc  = pc;
        dec.rd  = inst[11:7];
        op_idx  = ALU_ADD;
        op_en   = 1'b1;
        wen     = 1'b0;
        case (opcode)
            OPC_OP: begin
                wen = 1'b1;
                case (funct3)
                    F3_ADD_SUB: op_idx = funct7[5] ? ALU_SUB : ALU_ADD;
                    F3_SLL:     op_idx = ALU_SLL;
                    F3_SLT:     op_idx = ALU_SLT;
                    F3_SLTU:    op_idx = ALU_SLTU;
                    F3_XOR:     op_idx = ALU_XOR;
                    F3_SRL_SRA: op_idx = funct7[5] ? ALU_SRA : ALU_SRL;
                    F3_OR:      op_idx = ALU_OR;
                    default:    op_idx = ALU_AND;
                endcase
                // Only sub and sra may carry the alternate funct7; M-extension etc. is rejected
                if (!(funct7 == F7_BASE ||
                      (funct7 == F7_ALT && (funct3 == F3_ADD_SUB || funct3 == F3_SRL_SRA))))
                    dec.ill = 1'b1;
            end
            OPC_OP_IMM: begin
                wen   = 1'b1;
                dec.b = i_imm;
                case (funct3)
                    F3_ADD_SUB: op_idx = ALU_ADD;
                    F3_SLT:     op_idx = ALU_SLT;
                    F3_SLTU:    op_idx = ALU_SLTU;
                    F3_XOR:     op_idx = ALU_XOR;
                    F3_OR:      op_idx = ALU_OR;
                    F3_AND:     op_idx = ALU_AND;
                    F3_SLL: begin
                        dec.b  = shamt;
                        op_idx = ALU_SLL;
                        if (funct7 != F7_BASE) dec.ill = 1'b1;
                    end
                    default: begin
                        dec.b = shamt;
                        if (funct7 == F7_ALT)       op_idx = ALU_SRA;
                        else if (funct7 == F7_BASE) op_idx = ALU_SRL;
                        else                        dec.ill = 1'b1;
                    end
                endcase
            end
            OPC_LUI: begin
                wen    = 1'b1;
                dec.a  = '0;
                dec.b  = u_imm;
                op_idx = ALU_LUI;
            end
            OPC_AUIPC: begin
                wen    = 1'b1;
                dec.a  = pc;
                dec.b  = u_imm;
                op_idx = ALU_AUIPC;
            end
            OPC_LOAD: begin
                wen   = 1'b1;
                dec.b = i_imm;
            end
            OPC_STORE: dec.b = s_imm;
            OPC_BRANCH: begin
                dec.br = 1'b1;
                case (funct3)
                    F3_BEQ:  op_idx = ALU_SUB;
                    F3_BNE:  begin op_idx = ALU_SUB;  dec.inv = 1'b1; end
                    F3_BLT:  op_idx = ALU_SLT;
                    F3_BGE:  begin op_idx = ALU_SLT;  dec.inv = 1'b1; end
                    F3_BLTU: op_idx = ALU_SLTU;
                    F3_BGEU: begin op_idx = ALU_SLTU; dec.inv = 1'b1; end
                    default: dec.ill = 1'b1;
                endcase
            end
            default: dec.ill = 1'b1;
        endcase
        if (dec.ill) begin
            wen     = 1'b0;
            dec.br  = 1'b0;
            dec.inv = 1'b0;
            op_idx  = ALU_ADD;
            op_en   = (ILLEGAL_AS_NOP == 0);
        end
        dec.op  = op_en ? (OP_WIDTH'(1) << op_idx) : '0;
        dec.wen = wen && (dec.rd != 5'd0);
    end

`ifdef ALU_ISSUE_SKID_EN
    entry_t skid_q;
    logic   skid_valid;

    assign in_ready = !skid_valid;

    // A stalled main slot diverts one accept into the skid entry; it drains first when the ALU frees up
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!out_valid || out_ready) begin
            if (skid_valid) begin
                main_q     <= skid_q;
                out_valid  <= 1'b1;
                skid_valid <= 1'b0;
            end else begin
                out_valid <= in_valid;
                if (in_valid) main_q <= dec;
            end
        end else if (in_valid && !skid_valid) begin
            skid_q     <= dec;
            skid_valid <= 1'b1;
        end
    end
`else
    assign in_ready = !out_valid || out_ready;

    // Payload is loaded on any accept; a flush only kills the valid bit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            main_q    <= '0;
        end else begin
            if (flush)         out_valid <= 1'b0;
            else if (in_ready) out_valid <= in_valid;
            if (in_valid && in_ready) main_q <= dec;
        end
    end
`endif

    assign alu_a     = main_q.a;
    assign alu_b     = main_q.b;
    assign alu_op    = main_q.op;
    assign rd        = main_q.rd;
    assign rf_wen    = main_q.wen;
    assign is_branch = main_q.br;
    assign br_inv    = main_q.inv;
    assign illegal   = main_q.ill;
    assign out_pc    = main_q.pc;

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: vector table through a scoreboard plus stall/flush/reset sequences.
module tb_alu_issue;

    typedef struct {
        int          id;
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [11:0] op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        wen;
        logic        br;
        logic        inv;
        logic        ill;
        logic        chk_ab;
    } vec_t;

`ifdef ALU_ISSUE_SKID_EN
    localparam logic STALL_READY = 1'b1;
`else
    localparam logic STALL_READY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] inst = '0;
    logic [31:0] pc = '0;
    logic [31:0] rs1_data = '0;
    logic [31:0] rs2_data = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [11:0] alu_op;
    logic [4:0]  rd;
    logic        rf_wen;
    logic        is_branch;
    logic        br_inv;
    logic        illegal;
    logic [31:0] out_pc;

    vec_t vecs[20];
    vec_t cur;
    vec_t exp_e;
    vec_t sb[$];
    int   tests_run = 0;
    int   fail_count = 0;

    alu_issue dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .inst      (inst),
        .pc        (pc),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .rd        (rd),
        .rf_wen    (rf_wen),
        .is_branch (is_branch),
        .br_inv    (br_inv),
        .illegal   (illegal),
        .out_pc    (out_pc)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(input int id, input logic [31:0] i, input logic [31:0] p,
                                input logic [31:0] r1, input logic [31:0] r2,
                                input logic [11:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [4:0] d, input logic wen, input logic br,
                                input logic inv, input logic ill, input logic chk);
        vec_t v;
        v.id = id; v.inst = i; v.pc = p; v.rs1 = r1; v.rs2 = r2;
        v.op = op; v.a = a; v.b = b; v.rd = d;
        v.wen = wen; v.br = br; v.inv = inv; v.ill = ill; v.chk_ab = chk;
        return v;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: pop on a consumed output first, then record any accept happening this cycle
    always @(negedge clk) begin
        if (rst) begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check_output("unexpected_issue", 32'd1, 32'd0);
                end else begin
                    exp_e = sb.pop_front();
                    check_output($sformatf("v%0d alu_op", exp_e.id), 32'(alu_op), 32'(exp_e.op));
                    check_output($sformatf("v%0d flags", exp_e.id),
                                 32'({rd, rf_wen, is_branch, br_inv, illegal}),
                                 32'({exp_e.rd, exp_e.wen, exp_e.br, exp_e.inv, exp_e.ill}));
                    check_output($sformatf("v%0d out_pc", exp_e.id), out_pc, exp_e.pc);
                    if (exp_e.chk_ab) begin
                        check_output($sformatf("v%0d alu_a", exp_e.id), alu_a, exp_e.a);
                        check_output($sformatf("v%0d alu_b", exp_e.id), alu_b, exp_e.b);
                    end
                end
            end
            if (in_valid && in_ready && !flush) sb.push_back(cur);
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge
    task automatic apply_stimulus(input vec_t v);
        bit ok;
        cur      = v;
        inst     = v.inst;
        pc       = v.pc;
        rs1_data = v.rs1;
        rs2_data = v.rs2;
        in_valid = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (!ok) check_output($sformatf("v%0d accept_timeout", v.id), 32'd0, 32'd1);
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            if (sb.size() == 0) ok = 1'b1;
        end
        check_output("drain", 32'(ok), 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = mk(0,  32'h002081B3, 32'h100, 32'd5,        32'd7,        12'h001, 32'd5,        32'd7,        5'd3,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        vecs[1]  = mk(1,  32'hABCDE2B7, 32'h104, 32'h1234,     32'h0,        12'h800, 32'h0,        32'h000ABCDE, 5'd5,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        vecs[2]  = mk(2,  32'h00001317, 32'h1000, 32'h55,      32'h66,       12'h010, 32'h1000,     32'h1,        5'd6,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        vecs[3]  = mk(3,  32'h40415093, 32'h10C, 32'h80000000, 32'h9,        12'h400, 32'h80000000, 32'd4,        5'd1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        vecs[4]  = mk(4,  32'h20415093, 32'h110, 32'h80000000, 32'h9,        12'h000, 32'h0,        32'h0,        5'd1,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        vecs[5]  = mk(5,  32'h0020F063, 32'h114, 32'd1,        32'hFFFFFFFF, 12'h080, 32'd1,        32'hFFFFFFFF, 5'd0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        vecs[6]  = mk(6,  32'h40208233, 32'h118, 32'd10,       32'd3,        12'h002, 32'd10,       32'd3,        5'd4,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        vecs[7]  = mk(7,  32'hFFF08013, 32'h11C, 32'd9,        32'd1,        12'h001, 32'd9,        32'hFFFFFFFF, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        vecs[8]  = mk(8,  32'hFFC12383, 32'h120, 32'h2000,     32'h0,        12'h001, 32'h2000,     32'hFFFFFFFC, 5'd7,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        vecs[9]  = mk(9,  32'h00512423, 32'h124, 32'h2000,     32'hDEAD,     12'h001, 32'h2000,     32'd8,        5'd8,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        vecs[10] = mk(10, 32'h00209063, 32'h128, 32'd3,        32'd4,        12'h002, 32'd3,        32'd4,        5'd0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        vecs[11] = mk(11, 32'h0020C063, 32'h12C, 32'd3,        32'd4,        12'h040, 32'd3,        32'd4,        5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        vecs[12] = mk(12, 32'h0000007F, 32'h130, 32'd1,        32'd2,        12'h000, 32'h0,        32'h0,        5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        vecs[13] = mk(13, 32'h0020A063, 32'h134, 32'd1,        32'd2,        12'h000, 32'h0,        32'h0,        5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        vecs[14] = mk(14, 32'h0F00C493, 32'h138, 32'hFF,       32'h0,        12'h020, 32'hFF,       32'hF0,       5'd9,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        vecs[15] = mk(15, 32'h0020B533, 32'h13C, 32'd1,        32'd2,        12'h080, 32'd1,        32'd2,        5'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        vecs[16] = mk(16, 32'h022081B3, 32'h140, 32'd1,        32'd2,        12'h000, 32'h0,        32'h0,        5'd3,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        vecs[17] = mk(17, 32'h01F09093, 32'h144, 32'h1,        32'h0,        12'h100, 32'h1,        32'd31,       5'd1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        vecs[18] = mk(18, 32'h007362B3, 32'h148, 32'hF0,       32'h0F,       12'h008, 32'hF0,       32'h0F,       5'd5,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        vecs[19] = mk(19, 32'h403150B3, 32'h14C, 32'h80000000, 32'd3,        12'h400, 32'h80000000, 32'd3,        5'd1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

        // Reset state
        @(negedge clk);
        check_output("reset out_valid", 32'(out_valid), 32'd0);
        check_output("reset alu_op", 32'(alu_op), 32'd0);
        check_output("reset in_ready", 32'(in_ready), 32'd1);
        check_output("reset flags", 32'({rd, rf_wen, is_branch, br_inv, illegal}), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        out_ready = 1'b1;

        // Back-to-back table vectors
        for (int i = 0; i < 20; i++) apply_stimulus(vecs[i]);
        drain();

        // Stall: entry held for three cycles, then a second instruction queued behind it
        out_ready = 1'b0;
        apply_stimulus(vecs[0]);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_output($sformatf("stall%0d out_valid", k), 32'(out_valid), 32'd1);
            check_output($sformatf("stall%0d alu_a", k), alu_a, 32'd5);
            check_output($sformatf("stall%0d alu_b", k), alu_b, 32'd7);
            check_output($sformatf("stall%0d alu_op", k), 32'(alu_op), 32'h001);
            check_output($sformatf("stall%0d in_ready", k), 32'(in_ready), 32'(STALL_READY));
        end
        @(posedge clk);
        #1;
        fork
            apply_stimulus(vecs[6]);
            begin
                @(negedge clk);
                @(negedge clk);
                check_output("stall2 in_ready", 32'(in_ready), 32'd0);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Flush concurrent with an accept on an empty slot
        cur      = vecs[1];
        inst     = vecs[1].inst;
        pc       = vecs[1].pc;
        in_valid = 1'b1;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        @(negedge clk);
        check_output("flush_accept out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;

        // Flush of a held entry while another instruction is offered
        out_ready = 1'b0;
        apply_stimulus(vecs[2]);
        cur      = vecs[3];
        inst     = vecs[3].inst;
        pc       = vecs[3].pc;
        rs1_data = vecs[3].rs1;
        in_valid = 1'b1;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        sb.delete();
        @(negedge clk);
        check_output("flush_held out_valid", 32'(out_valid), 32'd0);
        check_output("flush_held in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        check_output("flush_after out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;

        // Asynchronous reset while an entry is held
        out_ready = 1'b0;
        apply_stimulus(vecs[14]);
        check_output("pre_reset out_valid", 32'(out_valid), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check_output("async_reset out_valid", 32'(out_valid), 32'd0);
        check_output("async_reset alu_op", 32'(alu_op), 32'd0);
        check_output("async_reset alu_a", alu_a, 32'd0);
        check_output("async_reset in_ready", 32'(in_ready), 32'd1);
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
        out_ready = 1'b1;

        // Recovery after reset
        apply_stimulus(vecs[5]);
        apply_stimulus(vecs[17]);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end

endmodule
